// File: rtl/sm_imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package sm_imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_SUM
    } state_t;

    // Frame start marker; only recognised while idle.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // A frame length is usable when it is non-zero and fits the RAM.
    function automatic logic len_ok(input logic [15:0] len, input int unsigned aw);
        return (len != 16'd0) && ({1'b0, len} <= 17'(32'd1 << aw));
    endfunction

endpackage

// File: rtl/sm_imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the loader.
interface sm_imem_loader_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    // Loader side: consumes the stream, drives the RAM write port.
    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    // Environment side: byte source and instruction RAM.
    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/sm_imem_loader_wordpack.sv
// Packs payload bytes little-endian into 32-bit words and emits a
// one-cycle ready pulse together with the completed word.
module sm_imem_loader_wordpack
    import sm_imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    output logic        o_last_lane,
    output logic        o_word_rdy,
    output logic [31:0] o_word
);

    logic [1:0]  r_lane;
    logic [23:0] r_shift;
    logic        r_word_rdy;
    logic [31:0] r_word;

    // Collect lanes 0..2, then publish the full word when lane 3 arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane     <= 2'd0;
            r_shift    <= 24'd0;
            r_word_rdy <= 1'b0;
            r_word     <= 32'd0;
        end else begin
            r_word_rdy <= 1'b0;
            if (i_clear) begin
                r_lane <= 2'd0;
            end else if (i_byte_vld) begin
                r_lane <= r_lane + 2'd1;
                case (r_lane)
                    2'd0:    r_shift[7:0]   <= i_byte;
                    2'd1:    r_shift[15:8]  <= i_byte;
                    2'd2:    r_shift[23:16] <= i_byte;
                    default: begin
                        r_word     <= {i_byte, r_shift};
                        r_word_rdy <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_last_lane = (r_lane == 2'd3);
    assign o_word_rdy  = r_word_rdy;
    assign o_word      = r_word;

endmodule

// File: rtl/sm_imem_loader.sv
// Loads a framed byte stream into instruction RAM from word 0 and keeps
// the CPU in reset until a frame with a valid checksum has been written.
module sm_imem_loader
    import sm_imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter bit HOLD_AT_RESET  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    sm_imem_loader_if.master  bus,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;
    logic                  w_sync;
    logic                  w_abort;
    logic                  w_good;
    logic                  w_timeout;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic [15:0]           w_len_full;
    logic [7:0]            r_sum;
    logic [7:0]            w_sum_nxt;
    logic [15:0]           r_wcnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [TO_W-1:0]       r_idle;
    logic [TO_W-1:0]       w_idle_nxt;
    logic                  w_pack_vld;
    logic                  w_last_lane;
    logic                  w_word_last;
    logic                  w_word_rdy;
    logic [31:0]           w_word;
    logic                  r_cpu_rst_n;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    // The loader never back-pressures; it is ready whenever out of reset.
    assign bus.in_ready = rst_n;
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_len_full   = {bus.in_data, r_len_lo};
    assign w_sum_nxt    = r_sum + bus.in_data;
    assign w_idle_nxt   = r_idle + TO_W'(1);
    assign w_pack_vld   = w_accept && (r_state == S_DATA);
    assign w_word_last  = w_last_lane && (r_wcnt == r_len - 16'd1);
    // An accepted byte in the limit cycle suppresses the timeout.
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_state != S_IDLE) &&
                          !w_accept && (w_idle_nxt == TO_LIMIT);

    sm_imem_loader_wordpack u_wordpack (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_sync),
        .i_byte_vld  (w_pack_vld),
        .i_byte      (bus.in_data),
        .o_last_lane (w_last_lane),
        .o_word_rdy  (w_word_rdy),
        .o_word      (w_word)
    );

    // Frame state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; all abort causes share one path back to idle.
    always_comb begin
        w_state_nxt = r_state;
        w_sync      = 1'b0;
        w_abort     = 1'b0;
        w_good      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (bus.in_data == SYNC_BYTE)) begin
                    w_sync      = 1'b1;
                    w_state_nxt = S_LEN0;
                end
            end
            S_LEN0: begin
                if (w_accept) w_state_nxt = S_LEN1;
            end
            S_LEN1: begin
                if (w_accept) begin
                    if (len_ok(w_len_full, ADDR_WIDTH)) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_abort     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && w_word_last) w_state_nxt = S_SUM;
            end
            S_SUM: begin
                if (w_accept) begin
                    w_state_nxt = S_IDLE;
                    if (w_sum_nxt == 8'd0) w_good  = 1'b1;
                    else                   w_abort = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_abort     = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    // Length capture, running checksum, word index, write address, idle timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len_lo <= 8'd0;
            r_len    <= 16'd0;
            r_sum    <= 8'd0;
            r_wcnt   <= 16'd0;
            r_addr   <= '0;
            r_idle   <= '0;
        end else begin
            if ((r_state == S_IDLE) || w_accept) r_idle <= '0;
            else                                 r_idle <= w_idle_nxt;

            if (w_sync)                                  r_sum <= 8'd0;
            else if (w_accept && (r_state != S_IDLE))    r_sum <= w_sum_nxt;

            if (w_accept && (r_state == S_LEN0)) r_len_lo <= bus.in_data;

            if (w_accept && (r_state == S_LEN1)) begin
                r_len  <= w_len_full;
                r_wcnt <= 16'd0;
            end else if (w_pack_vld && w_last_lane) begin
                r_addr <= r_wcnt[ADDR_WIDTH-1:0];
                r_wcnt <= r_wcnt + 16'd1;
            end
        end
    end

    // Sticky status and CPU reset, updated on frame start, abort or success.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cpu_rst_n <= ~HOLD_AT_RESET;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_sync) begin
            r_cpu_rst_n <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_abort) begin
            r_cpu_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b1;
        end else if (w_good) begin
            r_cpu_rst_n <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
        end
    end

    assign bus.imem_we    = w_word_rdy;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = w_word;
    assign cpu_rst_n      = r_cpu_rst_n;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;

endmodule

// File: tb/tb_sm_imem_loader.sv
// Scoreboard bench for sm_imem_loader: expected RAM writes are queued as
// frames are driven and matched against the write strobe as it appears.
module tb_sm_imem_loader;
    import sm_imem_loader_pkg::*;

    localparam int AW = 6;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_rst_n, busy, done, err;

    sm_imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    sm_imem_loader #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO),
        .HOLD_AT_RESET  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            due;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] ram   [0:63];
    logic [31:0] words [0:63];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle counter and a simple model of the instruction RAM.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.imem_we) ram[bus.imem_addr] <= bus.imem_wdata;
    end

    // Match every write strobe against the scoreboard head, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.imem_we) begin
            if (sb_q.size() == 0) begin
                check("we_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("we_addr",  32'(bus.imem_addr), 32'(e.addr));
                check("we_data",  bus.imem_wdata, e.data);
                check("we_cycle", cyc, e.due);
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check("we_missing", 32'd0, 32'd1);
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no end expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // The 4th byte of a word is accepted at the next edge; the strobe follows one cycle later.
    task automatic push_exp(input int a, input logic [31:0] d);
        exp_t e;
        e.addr = AW'(a);
        e.data = d;
        e.due  = cyc + 1;
        sb_q.push_back(e);
    endtask

    // Sends a full frame of nw words from words[]; delta corrupts the checksum when non-zero.
    task automatic send_frame(input int nw, input logic [7:0] delta);
        logic [7:0] s, b, lo, hi;
        lo = 8'(nw);
        hi = 8'(nw >> 8);
        send_byte(SYNC_BYTE);
        check("sync_busy", 32'(busy), 32'd1);
        check("sync_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("sync_done", 32'(done), 32'd0);
        check("sync_err", 32'(err), 32'd0);
        s = lo + hi;
        send_byte(lo);
        send_byte(hi);
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = words[w][8*k +: 8];
                s = s + b;
                if (k == 3) push_exp(w, words[w]);
                send_byte(b);
            end
        end
        send_byte(8'(delta - s));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n        = 1'b0;
        idle(3);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_we", 32'(bus.imem_we), 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_wdata", bus.imem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        rst_n = 1'b1;
        idle(1);
        check("run_in_ready", 32'(bus.in_ready), 32'd1);
        check("run_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

        // Good two-word frame.
        words[0] = 32'h44332211;
        words[1] = 32'h88776655;
        send_frame(2, 8'd0);
        check("good_done", 32'(done), 32'd1);
        check("good_err", 32'(err), 32'd0);
        check("good_busy", 32'(busy), 32'd0);
        check("good_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        idle(3);
        check("hold_addr", 32'(bus.imem_addr), 32'd1);
        check("hold_wdata", bus.imem_wdata, 32'h88776655);
        check("ram0", ram[0], 32'h44332211);
        check("ram1", ram[1], 32'h88776655);

        // Same frame with a bad checksum: writes happen, frame fails.
        send_frame(2, 8'd1);
        check("badsum_err", 32'(err), 32'd1);
        check("badsum_done", 32'(done), 32'd0);
        check("badsum_busy", 32'(busy), 32'd0);
        check("badsum_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

        // Length too large, then zero length.
        send_byte(SYNC_BYTE);
        check("len41_err_clr", 32'(err), 32'd0);
        send_byte(8'h41);
        send_byte(8'h00);
        check("len41_err", 32'(err), 32'd1);
        check("len41_busy", 32'(busy), 32'd0);
        send_byte(SYNC_BYTE);
        send_byte(8'h00);
        send_byte(8'h00);
        check("len0_err", 32'(err), 32'd1);
        idle(2);

        // Largest frame that fits the RAM.
        for (int w = 0; w < 64; w++) words[w] = {8'(w), 8'(~w), 8'(w * 3), 8'(w + 8'h5A)};
        send_frame(64, 8'd0);
        check("len64_done", 32'(done), 32'd1);
        check("len64_cpu_rst_n", 32'(cpu_rst_n), 32'd1);

        // Timeout: a byte on the limit cycle wins, a full idle stretch aborts.
        send_byte(SYNC_BYTE);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        idle(15);
        send_byte(8'h22);
        check("to_edge_err", 32'(err), 32'd0);
        check("to_edge_busy", 32'(busy), 32'd1);
        idle(15);
        check("to_pre_err", 32'(err), 32'd0);
        idle(1);
        check("to_err", 32'(err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h12345678;
        words[2] = 32'hA5A5A5A5;
        send_frame(3, 8'd0);
        check("after_to_done", 32'(done), 32'd1);
        check("after_to_err", 32'(err), 32'd0);

        // Garbage before a frame is discarded.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("garbage_busy", 32'(busy), 32'd0);
        words[0] = 32'hCAFEF00D;
        send_frame(1, 8'd0);
        check("garbage_done", 32'(done), 32'd1);

        // Reset in the middle of the payload.
        send_byte(SYNC_BYTE);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        push_exp(0, 32'h44332211);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        rst_n = 1'b0;
        idle(1);
        check("midrst_we", 32'(bus.imem_we), 32'd0);
        check("midrst_addr", 32'(bus.imem_addr), 32'd0);
        check("midrst_wdata", bus.imem_wdata, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        rst_n = 1'b1;
        send_byte(8'h77);
        send_byte(8'h88);
        idle(5);
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_err", 32'(err), 32'd0);
        check("postrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

        idle(3);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
